// File: rtl/cache_mem_l2_nway.sv
// N-way set-associative L2 storage: p1 read/byte-write/fill, p2 read/fill, true-LRU, dirty write-back.
// Latency: one cycle, registered outputs; storage updates on the request edge.
// Backpressure: none; busy_o during the post-reset sweep, conflict_p2_o when a p2 op is dropped.
module cache_mem_l2_nway #(
    parameter int BLOCK_SIZE = 128,
    parameter int TAG_SIZE   = 7,
    parameter int IDX_SIZE   = 8,
    parameter int WAYS       = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         rd_p1_i,
    input  logic                         wr_p1_i,
    input  logic                         fill_p1_i,
    input  logic [TAG_SIZE+IDX_SIZE-1:0] addr_p1_i,
    input  logic [BLOCK_SIZE-1:0]        data_block_p1_i,
    input  logic [BLOCK_SIZE/8-1:0]      byte_enable_p1_i,
    input  logic                         rd_p2_i,
    input  logic                         fill_p2_i,
    input  logic [TAG_SIZE+IDX_SIZE-1:0] addr_p2_i,
    input  logic [BLOCK_SIZE-1:0]        data_block_p2_i,
    output logic                         busy_o,
    output logic                         hit_p1_o,
    output logic [BLOCK_SIZE-1:0]        data_block_p1_o,
    output logic                         hit_p2_o,
    output logic [BLOCK_SIZE-1:0]        data_block_p2_o,
    output logic                         conflict_p2_o,
    output logic                         evict_valid_o,
    output logic [TAG_SIZE+IDX_SIZE-1:0] evict_addr_o,
    output logic [BLOCK_SIZE-1:0]        evict_block_o
);
    localparam int SETS = 1 << IDX_SIZE;
    localparam int AW   = $clog2(WAYS);
    localparam int BE   = BLOCK_SIZE / 8;

    typedef enum logic {INIT, READY} state_t;

    typedef struct packed {
        logic [WAYS-1:0]                 valid;
        logic [WAYS-1:0]                 dirty;
        logic [WAYS-1:0][AW-1:0]         age;
        logic [WAYS-1:0][TAG_SIZE-1:0]   tag;
        logic [WAYS-1:0][BLOCK_SIZE-1:0] data;
    } set_t;

    logic [BLOCK_SIZE-1:0] data_q  [SETS][WAYS];
    logic [TAG_SIZE-1:0]   tag_q   [SETS][WAYS];
    logic [AW-1:0]         age_q   [SETS][WAYS];
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];

    state_t                state_q, state_d;
    logic [IDX_SIZE-1:0]   init_idx_q;

    logic                  rdy, rd1, wr1, fill1, rd2, fill2, same_idx, conflict2;
    logic [IDX_SIZE-1:0]   idx1, idx2;
    logic [TAG_SIZE-1:0]   tag1, tag2, ev_tag1, ev_tag2;
    set_t                  set1_in, set1_out, set2_in, set2_out;
    logic                  hit1, hit2, ev1, ev2;
    logic [BLOCK_SIZE-1:0] rdata1, rdata2, ev_data1, ev_data2;

    function automatic set_t read_set(input logic [IDX_SIZE-1:0] idx);
        set_t s;
        s.valid = valid_q[idx];
        s.dirty = dirty_q[idx];
        for (int w = 0; w < WAYS; w++) begin
            s.age[w]  = age_q[idx][w];
            s.tag[w]  = tag_q[idx][w];
            s.data[w] = data_q[idx][w];
        end
        return s;
    endfunction

    // Accessed way becomes age 0; every younger way ages by one.
    function automatic logic [WAYS-1:0][AW-1:0] lru_touch(input logic [WAYS-1:0][AW-1:0] age,
                                                         input logic [AW-1:0] k);
        logic [WAYS-1:0][AW-1:0] r;
        for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == k)
                r[w] = '0;
            else if (age[w] < age[k])
                r[w] = age[w] + 1'b1;
            else
                r[w] = age[w];
        end
        return r;
    endfunction

    function automatic void apply_op(
        input  set_t                  s_in,
        input  logic                  do_rd,
        input  logic                  do_wr,
        input  logic                  do_fill,
        input  logic [TAG_SIZE-1:0]   tag,
        input  logic [BLOCK_SIZE-1:0] wdata,
        input  logic [BE-1:0]         be,
        output set_t                  s_out,
        output logic                  hit,
        output logic [BLOCK_SIZE-1:0] rdata,
        output logic                  evict,
        output logic [TAG_SIZE-1:0]   ev_tag,
        output logic [BLOCK_SIZE-1:0] ev_data
    );
        logic                  found, free;
        logic [AW-1:0]         hway, way;
        logic [BLOCK_SIZE-1:0] line;
        s_out   = s_in;
        hit     = 1'b0;
        rdata   = '0;
        evict   = 1'b0;
        ev_tag  = '0;
        ev_data = '0;
        found   = 1'b0;
        free    = 1'b0;
        hway    = '0;
        way     = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && s_in.valid[w] && s_in.tag[w] == tag) begin
                found = 1'b1;
                hway  = AW'(w);
            end
        end
        if (do_fill) begin
            if (found) begin
                way = hway;
            end else begin
                for (int w = 0; w < WAYS; w++) begin
                    if (!free && !s_in.valid[w]) begin
                        free = 1'b1;
                        way  = AW'(w);
                    end
                end
                if (!free) begin
                    for (int w = 0; w < WAYS; w++)
                        if (s_in.age[w] == AW'(WAYS-1)) way = AW'(w);
                end
                if (s_in.valid[way] && s_in.dirty[way]) begin
                    evict   = 1'b1;
                    ev_tag  = s_in.tag[way];
                    ev_data = s_in.data[way];
                end
            end
            s_out.valid[way] = 1'b1;
            s_out.dirty[way] = 1'b0;
            s_out.tag[way]   = tag;
            s_out.data[way]  = wdata;
            s_out.age        = lru_touch(s_in.age, way);
        end else if (do_wr && found) begin
            line = s_in.data[hway];
            for (int b = 0; b < BE; b++)
                if (be[b]) line[b*8 +: 8] = wdata[b*8 +: 8];
            s_out.data[hway]  = line;
            s_out.dirty[hway] = 1'b1;
            s_out.age         = lru_touch(s_in.age, hway);
            hit               = 1'b1;
            rdata             = line;
        end else if (do_rd && found) begin
            s_out.age = lru_touch(s_in.age, hway);
            hit       = 1'b1;
            rdata     = s_in.data[hway];
        end
    endfunction

    assign busy_o = (state_q == INIT);
    assign {tag1, idx1} = addr_p1_i;
    assign {tag2, idx2} = addr_p2_i;

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && init_idx_q == IDX_SIZE'(SETS-1))
            state_d = READY;
    end

    // p2 is evaluated on the set as p1 leaves it, so same-index reads order p1 before p2.
    always_comb begin
        rdy      = (state_q == READY);
        fill1    = rdy & fill_p1_i;
        wr1      = rdy & wr_p1_i & ~fill_p1_i;
        rd1      = rdy & rd_p1_i & ~fill_p1_i & ~wr_p1_i;
        fill2    = rdy & fill_p2_i;
        rd2      = rdy & rd_p2_i & ~fill_p2_i;
        same_idx = (idx1 == idx2);
        set1_in  = read_set(idx1);
        apply_op(set1_in, rd1, wr1, fill1, tag1, data_block_p1_i, byte_enable_p1_i,
                 set1_out, hit1, rdata1, ev1, ev_tag1, ev_data1);
        set2_in  = same_idx ? set1_out : read_set(idx2);
        apply_op(set2_in, rd2, 1'b0, fill2, tag2, data_block_p2_i, '0,
                 set2_out, hit2, rdata2, ev2, ev_tag2, ev_data2);
        conflict2 = (rd2 | fill2) & ((same_idx & (wr1 | fill1)) | (ev1 & ev2));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= INIT;
            init_idx_q      <= '0;
            hit_p1_o        <= 1'b0;
            data_block_p1_o <= '0;
            hit_p2_o        <= 1'b0;
            data_block_p2_o <= '0;
            conflict_p2_o   <= 1'b0;
            evict_valid_o   <= 1'b0;
            evict_addr_o    <= '0;
            evict_block_o   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                valid_q[init_idx_q] <= '0;
                dirty_q[init_idx_q] <= '0;
                for (int w = 0; w < WAYS; w++)
                    age_q[init_idx_q][w] <= AW'(w);
                init_idx_q      <= init_idx_q + 1'b1;
                hit_p1_o        <= 1'b0;
                data_block_p1_o <= '0;
                hit_p2_o        <= 1'b0;
                data_block_p2_o <= '0;
                conflict_p2_o   <= 1'b0;
                evict_valid_o   <= 1'b0;
                evict_addr_o    <= '0;
                evict_block_o   <= '0;
            end else begin
                if (rd1 | wr1 | fill1) begin
                    valid_q[idx1] <= set1_out.valid;
                    dirty_q[idx1] <= set1_out.dirty;
                    for (int w = 0; w < WAYS; w++) begin
                        age_q[idx1][w]  <= set1_out.age[w];
                        tag_q[idx1][w]  <= set1_out.tag[w];
                        data_q[idx1][w] <= set1_out.data[w];
                    end
                end
                if ((rd2 | fill2) && !conflict2) begin
                    valid_q[idx2] <= set2_out.valid;
                    dirty_q[idx2] <= set2_out.dirty;
                    for (int w = 0; w < WAYS; w++) begin
                        age_q[idx2][w]  <= set2_out.age[w];
                        tag_q[idx2][w]  <= set2_out.tag[w];
                        data_q[idx2][w] <= set2_out.data[w];
                    end
                end
                hit_p1_o        <= hit1;
                data_block_p1_o <= rdata1;
                hit_p2_o        <= hit2 & ~conflict2;
                data_block_p2_o <= conflict2 ? '0 : rdata2;
                conflict_p2_o   <= conflict2;
                if (ev1) begin
                    evict_valid_o <= 1'b1;
                    evict_addr_o  <= {ev_tag1, idx1};
                    evict_block_o <= ev_data1;
                end else if (ev2 && !conflict2) begin
                    evict_valid_o <= 1'b1;
                    evict_addr_o  <= {ev_tag2, idx2};
                    evict_block_o <= ev_data2;
                end else begin
                    evict_valid_o <= 1'b0;
                    evict_addr_o  <= '0;
                    evict_block_o <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_mem_l2_nway.sv
// Bench for cache_mem_l2_nway: directed scenarios then random traffic against a list-based LRU model.
module tb_cache_mem_l2_nway;
    logic         clk = 1'b0;
    logic         rst_i;
    logic         rd_p1, wr_p1, fill_p1, rd_p2, fill_p2;
    logic [14:0]  addr_p1, addr_p2;
    logic [127:0] data_p1, data_p2;
    logic [15:0]  be_p1;
    logic         busy_o, hit_p1_o, hit_p2_o, conflict_p2_o, evict_valid_o;
    logic [127:0] data_block_p1_o, data_block_p2_o, evict_block_o;
    logic [14:0]  evict_addr_o;

    int checks = 0;
    int errors = 0;

    // Reference model: per-set way contents plus recency list (position 0 = most recent).
    bit           m_valid [256][4];
    bit           m_dirty [256][4];
    logic [6:0]   m_tag   [256][4];
    logic [127:0] m_data  [256][4];
    int           m_order [256][4];

    logic         e_hit1, e_hit2, e_conf, e_ev;
    logic [127:0] e_d1, e_d2, e_eblk;
    logic [14:0]  e_eaddr;

    cache_mem_l2_nway dut (
        .clk_i(clk), .rst_i(rst_i),
        .rd_p1_i(rd_p1), .wr_p1_i(wr_p1), .fill_p1_i(fill_p1), .addr_p1_i(addr_p1),
        .data_block_p1_i(data_p1), .byte_enable_p1_i(be_p1),
        .rd_p2_i(rd_p2), .fill_p2_i(fill_p2), .addr_p2_i(addr_p2), .data_block_p2_i(data_p2),
        .busy_o(busy_o), .hit_p1_o(hit_p1_o), .data_block_p1_o(data_block_p1_o),
        .hit_p2_o(hit_p2_o), .data_block_p2_o(data_block_p2_o), .conflict_p2_o(conflict_p2_o),
        .evict_valid_o(evict_valid_o), .evict_addr_o(evict_addr_o), .evict_block_o(evict_block_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 256; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_order[s][w] = w;
            end
    endtask

    function automatic int find(input int s, input logic [6:0] t);
        for (int w = 0; w < 4; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int victim(input int s);
        for (int w = 0; w < 4; w++)
            if (!m_valid[s][w]) return w;
        return m_order[s][3];
    endfunction

    task automatic touch(input int s, input int way);
        int p = 0;
        for (int k = 0; k < 4; k++)
            if (m_order[s][k] == way) p = k;
        for (int k = p; k > 0; k--)
            m_order[s][k] = m_order[s][k-1];
        m_order[s][0] = way;
    endtask

    task automatic model_step();
        int i1, i2, w, v;
        logic [6:0] t1, t2;
        bit f1, w1, r1, f2, r2, conf, ev1;
        f1 = fill_p1; w1 = wr_p1 && !f1; r1 = rd_p1 && !f1 && !w1;
        f2 = fill_p2; r2 = rd_p2 && !f2;
        i1 = int'(addr_p1[7:0]); t1 = addr_p1[14:8];
        i2 = int'(addr_p2[7:0]); t2 = addr_p2[14:8];
        e_hit1 = 0; e_hit2 = 0; e_conf = 0; e_ev = 0;
        e_d1 = '0; e_d2 = '0; e_eblk = '0; e_eaddr = '0;
        ev1 = 0;
        w = find(i1, t1);
        if (f1) begin
            if (w < 0) begin
                w = victim(i1);
                if (m_valid[i1][w] && m_dirty[i1][w]) begin
                    ev1 = 1; e_ev = 1;
                    e_eaddr = {m_tag[i1][w], 8'(i1)};
                    e_eblk = m_data[i1][w];
                end
            end
            m_valid[i1][w] = 1; m_dirty[i1][w] = 0;
            m_tag[i1][w] = t1; m_data[i1][w] = data_p1;
            touch(i1, w);
        end else if (w1 && w >= 0) begin
            for (int b = 0; b < 16; b++)
                if (be_p1[b]) m_data[i1][w][8*b +: 8] = data_p1[8*b +: 8];
            m_dirty[i1][w] = 1;
            touch(i1, w);
            e_hit1 = 1; e_d1 = m_data[i1][w];
        end else if (r1 && w >= 0) begin
            touch(i1, w);
            e_hit1 = 1; e_d1 = m_data[i1][w];
        end
        conf = (f2 || r2) && i1 == i2 && (f1 || w1);
        if (!conf && f2 && find(i2, t2) < 0) begin
            v = victim(i2);
            if (m_valid[i2][v] && m_dirty[i2][v]) begin
                if (ev1) conf = 1;
                else begin
                    e_ev = 1;
                    e_eaddr = {m_tag[i2][v], 8'(i2)};
                    e_eblk = m_data[i2][v];
                end
            end
        end
        if (!conf) begin
            w = find(i2, t2);
            if (f2) begin
                if (w < 0) w = victim(i2);
                m_valid[i2][w] = 1; m_dirty[i2][w] = 0;
                m_tag[i2][w] = t2; m_data[i2][w] = data_p2;
                touch(i2, w);
            end else if (r2 && w >= 0) begin
                touch(i2, w);
                e_hit2 = 1; e_d2 = m_data[i2][w];
            end
        end
        e_conf = conf;
    endtask

    task automatic step(input bit r1, input bit w1, input bit f1, input logic [14:0] a1,
                        input logic [127:0] d1, input logic [15:0] be,
                        input bit r2, input bit f2, input logic [14:0] a2, input logic [127:0] d2);
        rd_p1 = r1; wr_p1 = w1; fill_p1 = f1; addr_p1 = a1; data_p1 = d1; be_p1 = be;
        rd_p2 = r2; fill_p2 = f2; addr_p2 = a2; data_p2 = d2;
        model_step();
        @(posedge clk); #1;
        chk("busy", 128'(busy_o), 128'(0));
        chk("hit_p1", 128'(hit_p1_o), 128'(e_hit1));
        chk("data_p1", data_block_p1_o, e_d1);
        chk("hit_p2", 128'(hit_p2_o), 128'(e_hit2));
        chk("data_p2", data_block_p2_o, e_d2);
        chk("conflict_p2", 128'(conflict_p2_o), 128'(e_conf));
        chk("evict_valid", 128'(evict_valid_o), 128'(e_ev));
        chk("evict_addr", 128'(evict_addr_o), 128'(e_eaddr));
        chk("evict_block", evict_block_o, e_eblk);
        rd_p1 = 0; wr_p1 = 0; fill_p1 = 0; rd_p2 = 0; fill_p2 = 0;
    endtask

    task automatic rd1(input logic [14:0] a);
        step(1, 0, 0, a, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic fill1(input logic [14:0] a, input logic [127:0] d);
        step(0, 0, 1, a, d, '0, 0, 0, '0, '0);
    endtask

    task automatic do_reset(input int pre_cycles, input string tag);
        int n = 0;
        rst_i = 1;
        rd_p1 = 0; wr_p1 = 0; fill_p1 = 0; rd_p2 = 0; fill_p2 = 0;
        @(posedge clk); #1;
        chk("rst_busy", 128'(busy_o), 128'(1));
        chk("rst_hit_p1", 128'(hit_p1_o), 128'(0));
        chk("rst_data_p1", data_block_p1_o, 128'(0));
        chk("rst_hit_p2", 128'(hit_p2_o), 128'(0));
        chk("rst_conflict", 128'(conflict_p2_o), 128'(0));
        chk("rst_evict", 128'(evict_valid_o), 128'(0));
        rst_i = 0;
        if (pre_cycles > 0) begin
            repeat (pre_cycles) @(posedge clk);
            #1;
            chk("mid_init_busy", 128'(busy_o), 128'(1));
            rst_i = 1;
            @(posedge clk); #1;
            rst_i = 0;
        end
        // Requests presented during the sweep must be ignored.
        fill_p1 = 1; addr_p1 = 15'h0123; data_p1 = '1;
        for (int k = 0; k < 400 && busy_o; k++) begin
            n++;
            @(posedge clk); #1;
        end
        fill_p1 = 0;
        chk(tag, 128'(n), 128'(256));
        model_reset();
    endtask

    initial begin
        logic [127:0] blk_a, blk_b;
        logic [14:0]  ra1, ra2;
        rst_i = 1;
        rd_p1 = 0; wr_p1 = 0; fill_p1 = 0; addr_p1 = '0; data_p1 = '0; be_p1 = '0;
        rd_p2 = 0; fill_p2 = 0; addr_p2 = '0; data_p2 = '0;
        blk_a = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        repeat (2) @(posedge clk);
        #1;

        do_reset(0, "busy_cycles");
        rd1(15'h0123);
        chk("miss_after_init", 128'(hit_p1_o), 128'(0));

        fill1(15'h0123, blk_a);
        rd1(15'h0123);
        chk("rd_hit", 128'(hit_p1_o), 128'(1));
        chk("rd_data", data_block_p1_o, blk_a);

        step(0, 1, 0, 15'h0123, 128'hFF, 16'h0001, 0, 0, '0, '0);
        chk("wr_hit", 128'(hit_p1_o), 128'(1));
        for (int t = 2; t <= 4; t++)
            fill1({7'(t), 8'h23}, 128'(t));
        fill1({7'd5, 8'h23}, 128'h5);
        chk("dirty_evict_vld", 128'(evict_valid_o), 128'(1));
        chk("dirty_evict_addr", 128'(evict_addr_o), 128'(15'h0123));
        blk_b = evict_block_o;
        chk("dirty_evict_byte", 128'(blk_b[7:0]), 128'(8'hFF));
        chk("dirty_evict_rest", 128'(blk_b[127:8]), 128'(blk_a[127:8]));

        for (int t = 0; t < 4; t++)
            fill1({7'(t), 8'h05}, 128'(t + 16));
        rd1({7'd0, 8'h05});
        fill1({7'd4, 8'h05}, 128'h44);
        chk("clean_victim_silent", 128'(evict_valid_o), 128'(0));
        rd1({7'd0, 8'h05});
        chk("lru_way0_kept", 128'(hit_p1_o), 128'(1));
        rd1({7'd1, 8'h05});
        chk("lru_way1_gone", 128'(hit_p1_o), 128'(0));
        step(1, 0, 0, {7'd2, 8'h05}, '0, '0, 1, 0, {7'd3, 8'h05}, '0);
        chk("dual_read_p1", 128'(hit_p1_o), 128'(1));
        chk("dual_read_p2", 128'(hit_p2_o), 128'(1));

        fill1({7'd0, 8'h07}, 128'h77);
        step(0, 1, 0, {7'd0, 8'h07}, 128'h1, 16'hFFFF, 0, 1, {7'd2, 8'h07}, 128'h2);
        chk("conflict_set", 128'(conflict_p2_o), 128'(1));
        step(0, 0, 0, '0, '0, '0, 1, 0, {7'd2, 8'h07}, '0);
        chk("conflict_dropped", 128'(hit_p2_o), 128'(0));

        for (int c = 0; c < 1500; c++) begin
            ra1 = {7'($urandom_range(0, 5)), 8'(8'h10 + $urandom_range(0, 2))};
            ra2 = {7'($urandom_range(0, 5)), 8'(8'h10 + $urandom_range(0, 2))};
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 ra1, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                 ra2, {$urandom, $urandom, $urandom, $urandom});
        end

        rd1({7'd0, 8'h05});
        do_reset(100, "busy_after_mid_reset");
        rd1({7'd0, 8'h05});
        chk("miss_after_mid_reset", 128'(hit_p1_o), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
